irq_request_ctrl: RTL and testbench
===================================

Name: irq_request_ctrl

Overview:
- Request-side counterpart to the PC interrupt logic.
- Captures raw external interrupt lines, synchronises and edge-detects them, and holds each request as a level on `interrupt_req[i]` until the PC acknowledges it with `interrupt_running[i]`.
- Tracks each line through service until the decoder's `interrupt_done[i]`.
- Bit 0 maps to PC interrupt1, bit 1 to interrupt2, bit 2 to interrupt3. The PC owns priority and preemption; this block only generates and retires requests.

Parameters:
- NUM_IRQ, 3, number of interrupt lines.
- SYNC_STAGES, 2, flip-flop stages per raw input synchroniser (minimum 2).
- LOST_W, 8, width of the saturating per-block lost-edge counter.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- irq_in  input  NUM_IRQ  raw external interrupt lines, asynchronous, rising edge is an event.
- irq_mask  input  NUM_IRQ  1 = line masked; request held back, edges still captured.
- interrupt_running  input  NUM_IRQ  from PC; acknowledge/in-service level per line.
- interrupt_done  input  NUM_IRQ  from op decode; one-cycle service-complete pulse per line.
- interrupt_req  output  NUM_IRQ  to PC interrupt1..3; request level.
- irq_pending  output  NUM_IRQ  line state is PEND (masked or not).
- irq_in_service  output  NUM_IRQ  line state is SERV.
- lost_cnt  output  LOST_W  saturating count of coalesced edges.
- proto_err  output  1  sticky protocol violation flag.
- serviced_cnt  output  NUM_IRQ*16  per-line completed-service counts (see Optional Feature).

Behaviour:
- Reset (clr_n low, asynchronous):
  - All synchronisers, edge registers, line FSMs and the again-flags clear.
  - `interrupt_req` = 0, `irq_pending` = 0, `irq_in_service` = 0, `lost_cnt` = 0, `proto_err` = 0, `serviced_cnt` = 0.
  - Reset mid-service drops all state; no request is replayed.
- Edge detect: `sync[i]` is the last synchroniser stage; `prev[i]` registers `sync[i]`; `evt[i]` = `sync[i] & ~prev[i]`.
- Latency: raw `irq_in` rising and sampled at edge k gives `interrupt_req` high after edge k+SYNC_STAGES, i.e. edge k+2 at default, when unmasked.
- Per-line FSM, states IDLE, PEND, SERV:
  - IDLE: `evt` -> PEND.
  - PEND: `interrupt_running[i]` sampled 1 -> SERV. `evt` while in PEND is coalesced; `lost_cnt` +1.
  - SERV: `interrupt_done[i]` -> IDLE, or -> PEND if `again[i]` is set; `again[i]` clears.
  - SERV: `evt` sets `again[i]`; if `again[i]` is already set, `lost_cnt` +1 instead.
- Outputs:
  - `interrupt_req[i]` = (state==PEND) & ~`irq_mask[i]`, combinational from registered state.
  - `interrupt_req[i]` deasserts the cycle after `running` is sampled.
- Mask: masking while in PEND drops `req` but keeps PEND. Unmasking reasserts `req` the same cycle. Masking has no effect in SERV.
- Simultaneous events in one cycle:
  - `evt` + `done` in SERV -> PEND (the edge is treated as again).
  - `evt` + `running` in PEND -> SERV with `again` set.
- Protocol errors, which set `proto_err` and hold it until reset:
  - `interrupt_done[i]` while not in SERV; the done is ignored.
  - `interrupt_running[i]` rising while in IDLE.
- `lost_cnt` saturates at all-ones; multiple lines losing edges in the same cycle add their count, saturating.
- Lines are independent; no cross-line priority in this block.

Optional Feature:
- Macro: IRQ_STATS_EN.
- Defined: each line has a 16-bit counter, incremented on every SERV->IDLE/PEND transition caused by `interrupt_done`. Counters wrap 0xFFFF -> 0 and are packed into `serviced_cnt`, line i at bits [16*i+15:16*i].
- Undefined: counters are not built and `serviced_cnt` is tied to 0.

Decomposition:
- Shared package `irq_pkg`:
  - line-state encoding IDLE=2'd0, PEND=2'd1, SERV=2'd2;
  - PC vector constants 32'h38, 32'h70, 32'hA8 for documentation and bench use;
  - default NUM_IRQ.
- Sub-module `irq_line`: one synchroniser + edge detector + FSM + again-flag, instantiated NUM_IRQ times. The top level holds `lost_cnt`, `proto_err` and the stats counters.

Test Plan:
- Single request: `irq_in[0]` 0->1 at edge 10, mask 0 -> `interrupt_req` = 3'b001 after edge 12; `running[0]`=1 at edge 15 -> req 0 after edge 15; `done[0]` pulse at edge 20 -> `irq_in_service[0]`=0; `serviced_cnt[15:0]`=1 when stats enabled.
- Coalescing: three edges on `irq_in[1]` during PEND -> `lost_cnt`=2, only one service. An edge during SERV -> re-PEND after `done`, `req[1]`=1 the cycle after `done`.
- Masking: `irq_mask[2]`=1, edge on `irq_in[2]` -> `irq_pending[2]`=1 and `interrupt_req[2]`=0; clear mask -> `interrupt_req[2]`=1 the same cycle.
- Nested: req0 serviced (SERV), then edge on line 2 -> `interrupt_req`=3'b100 while `irq_in_service`=3'b001; dones retire line 2 then line 0.
- Protocol error: `done[1]` pulse in IDLE -> `proto_err`=1 and stays 1; FSM stays IDLE.
- Reset mid-operation: clr_n low while line 0 is in SERV with again set -> all outputs 0 immediately; after release, no request until a new edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request controller: line-state encoding,
// PC vector addresses for interrupt1..3 and the default line count.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } line_state_e;

  localparam int NUM_IRQ_DEF = 3;

  localparam logic [31:0] PC_VEC_IRQ1 = 32'h38;
  localparam logic [31:0] PC_VEC_IRQ2 = 32'h70;
  localparam logic [31:0] PC_VEC_IRQ3 = 32'hA8;

endpackage

// File: rtl/irq_line.sv
// One interrupt line: input synchroniser, rising-edge detector, request FSM and
// the again-flag that remembers a single edge arriving while in service.
import irq_pkg::*;

module irq_line #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic irq_in,
  input  logic irq_mask,
  input  logic running,
  input  logic done,
  output logic req,
  output logic pending,
  output logic in_service,
  output logic lost,
  output logic done_ok,
  output logic err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   running_prev_q;
  logic                   again_q, again_d;
  line_state_e            state_q, state_d;
  logic                   evt;

  assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      running_prev_q <= 1'b0;
      again_q        <= 1'b0;
      state_q        <= IDLE;
    end else begin
      sync_q         <= {sync_q[SYNC_STAGES-2:0], irq_in};
      prev_q         <= sync_q[SYNC_STAGES-1];
      running_prev_q <= running;
      again_q        <= again_d;
      state_q        <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    again_d = again_q;
    lost    = 1'b0;
    done_ok = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (evt) state_d = PEND;
        if (done || (running && !running_prev_q)) err = 1'b1;
      end
      PEND: begin
        if (done) err = 1'b1;
        if (running) begin
          state_d = SERV;
          again_d = evt;
        end else if (evt) begin
          lost = 1'b1;
        end
      end
      SERV: begin
        if (done) begin
          // An edge coinciding with done counts as the again edge; a second
          // outstanding edge on top of a set again-flag is lost.
          done_ok = 1'b1;
          again_d = 1'b0;
          state_d = (again_q || evt) ? PEND : IDLE;
          lost    = again_q & evt;
        end else if (evt) begin
          if (again_q) lost = 1'b1;
          else         again_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        again_d = 1'b0;
      end
    endcase
  end

  assign pending    = (state_q == PEND);
  assign in_service = (state_q == SERV);
  assign req        = pending & ~irq_mask;

endmodule

// File: rtl/irq_request_ctrl.sv
// Interrupt request controller: NUM_IRQ independent lines plus the shared
// lost-edge counter, sticky protocol error and (with IRQ_STATS_EN) service counters.
import irq_pkg::*;

module irq_request_ctrl #(
  parameter int NUM_IRQ     = NUM_IRQ_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOST_W      = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_mask,
  input  logic [NUM_IRQ-1:0]    interrupt_running,
  input  logic [NUM_IRQ-1:0]    interrupt_done,
  output logic [NUM_IRQ-1:0]    interrupt_req,
  output logic [NUM_IRQ-1:0]    irq_pending,
  output logic [NUM_IRQ-1:0]    irq_in_service,
  output logic [LOST_W-1:0]     lost_cnt,
  output logic                  proto_err,
  output logic [NUM_IRQ*16-1:0] serviced_cnt
);

  logic [NUM_IRQ-1:0] lost_vec;
  logic [NUM_IRQ-1:0] done_ok_vec;
  logic [NUM_IRQ-1:0] err_vec;
  logic [LOST_W-1:0]  lost_cnt_q, lost_cnt_d;
  logic               proto_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      irq_line #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_line (
        .clk        (clk),
        .clr_n      (clr_n),
        .irq_in     (irq_in[gi]),
        .irq_mask   (irq_mask[gi]),
        .running    (interrupt_running[gi]),
        .done       (interrupt_done[gi]),
        .req        (interrupt_req[gi]),
        .pending    (irq_pending[gi]),
        .in_service (irq_in_service[gi]),
        .lost       (lost_vec[gi]),
        .done_ok    (done_ok_vec[gi]),
        .err        (err_vec[gi])
      );
    end
  endgenerate

  // Saturate per added edge so any number of simultaneous losses is safe.
  always_comb begin
    lost_cnt_d = lost_cnt_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (lost_vec[i] && (lost_cnt_d != {LOST_W{1'b1}}))
        lost_cnt_d = lost_cnt_d + {{(LOST_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      lost_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      lost_cnt_q  <= lost_cnt_d;
      proto_err_q <= proto_err_q | (|err_vec);
    end
  end

  assign lost_cnt  = lost_cnt_q;
  assign proto_err = proto_err_q;

`ifdef IRQ_STATS_EN
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_stats
      logic [15:0] svc_q;
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)               svc_q <= 16'd0;
        else if (done_ok_vec[gi]) svc_q <= svc_q + 16'd1;
      end
      assign serviced_cnt[16*gi +: 16] = svc_q;
    end
  endgenerate
`else
  logic stats_unused;
  assign stats_unused = |done_ok_vec;
  assign serviced_cnt = '0;
`endif

endmodule

// File: tb/tb_irq_request_ctrl.sv
// Directed bench for irq_request_ctrl: latency, coalescing, masking, nesting,
// protocol errors, lost-count saturation and reset mid-service.
module tb_irq_request_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [2:0]  irq_in, irq_mask, running, done;
  logic [2:0]  interrupt_req, irq_pending, irq_in_service;
  logic [7:0]  lost_cnt;
  logic        proto_err;
  logic [47:0] serviced_cnt;

  int checks = 0;
  int failures = 0;

`ifdef IRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  irq_request_ctrl dut (
    .clk               (clk),
    .clr_n             (clr_n),
    .irq_in            (irq_in),
    .irq_mask          (irq_mask),
    .interrupt_running (running),
    .interrupt_done    (done),
    .interrupt_req     (interrupt_req),
    .irq_pending       (irq_pending),
    .irq_in_service    (irq_in_service),
    .lost_cnt          (lost_cnt),
    .proto_err         (proto_err),
    .serviced_cnt      (serviced_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two cycles high, two low: one clean synchronised rising edge per line in m.
  task automatic pulse(input logic [2:0] m);
    irq_in = irq_in | m;
    tick();
    tick();
    irq_in = irq_in & ~m;
    tick();
    tick();
  endtask

  function automatic logic [47:0] svc(input logic [15:0] c2, input logic [15:0] c1,
                                      input logic [15:0] c0);
    return STATS ? {c2, c1, c0} : 48'd0;
  endfunction

  initial begin
    clr_n = 1'b0; irq_in = '0; irq_mask = '0; running = '0; done = '0;
    tick(); tick();
    check("rst_req", interrupt_req, 3'b000);
    check("rst_lost", lost_cnt, 8'd0);
    check("rst_err", proto_err, 1'b0);
    check("rst_svc", serviced_cnt, 48'd0);
    clr_n = 1'b1;
    tick();

    // Single request: two-edge latency, ack, done
    irq_in = 3'b001;
    tick();
    check("lat_edge1", interrupt_req, 3'b000);
    tick();
    check("lat_edge2_early", interrupt_req, 3'b000);
    tick();
    check("lat_req", interrupt_req, 3'b001);
    check("lat_pend", irq_pending, 3'b001);
    running = 3'b001;
    tick();
    check("ack_req_drop", interrupt_req, 3'b000);
    check("ack_serv", irq_in_service, 3'b001);
    tick(); tick();
    done = 3'b001;
    tick();
    done = '0; running = '0; irq_in = '0;
    check("done_serv", irq_in_service, 3'b000);
    check("done_svc", serviced_cnt, svc(16'd0, 16'd0, 16'd1));
    tick(); tick();

    // Coalescing on line 1
    pulse(3'b010); pulse(3'b010); pulse(3'b010);
    check("coal_lost", lost_cnt, 8'd2);
    check("coal_req", interrupt_req, 3'b010);
    running = 3'b010;
    tick();
    check("coal_serv", irq_in_service, 3'b010);
    pulse(3'b010);
    check("again_lost", lost_cnt, 8'd2);
    check("again_serv", irq_in_service, 3'b010);
    running = '0; done = 3'b010;
    tick();
    done = '0;
    check("again_repend", interrupt_req, 3'b010);
    running = 3'b010;
    tick();
    running = '0; done = 3'b010;
    tick();
    done = '0;
    check("coal_idle", irq_pending | irq_in_service, 3'b000);

    // Masking on line 2
    irq_mask = 3'b100;
    pulse(3'b100);
    check("mask_pend", irq_pending, 3'b100);
    check("mask_req", interrupt_req, 3'b000);
    irq_mask = '0;
    #1;
    check("unmask_req", interrupt_req, 3'b100);
    running = 3'b100;
    tick();
    running = '0; done = 3'b100;
    tick();
    done = '0;

    // Nested: line 0 in service, line 2 requests
    pulse(3'b001);
    running = 3'b001;
    tick();
    pulse(3'b100);
    check("nest_req", interrupt_req, 3'b100);
    check("nest_serv0", irq_in_service, 3'b001);
    running = 3'b101;
    tick();
    check("nest_serv2", irq_in_service, 3'b101);
    done = 3'b100; running = 3'b001;
    tick();
    done = '0;
    check("nest_ret2", irq_in_service, 3'b001);
    done = 3'b001; running = '0;
    tick();
    done = '0;
    check("nest_ret0", irq_in_service, 3'b000);
    check("nest_svc", serviced_cnt, svc(16'd2, 16'd2, 16'd2));

    // Protocol error: done while idle
    check("perr_pre", proto_err, 1'b0);
    done = 3'b010;
    tick();
    done = '0;
    check("perr_set", proto_err, 1'b1);
    check("perr_idle", irq_pending | irq_in_service, 3'b000);
    tick(); tick();
    check("perr_sticky", proto_err, 1'b1);

    // Simultaneous losses and saturation
    pulse(3'b111);
    check("multi_pend", irq_pending, 3'b111);
    pulse(3'b111);
    check("multi_lost", lost_cnt, 8'd5);
    for (int i = 0; i < 84; i++) pulse(3'b111);
    check("lost_sat", lost_cnt, 8'hFF);

    clr_n = 1'b0;
    #1;
    check("rst1_pend", irq_pending, 3'b000);
    check("rst1_lost", lost_cnt, 8'd0);
    check("rst1_err", proto_err, 1'b0);
    tick();
    clr_n = 1'b1;
    tick();

    // evt + running in PEND, done with again, evt + done in SERV
    pulse(3'b001);
    irq_in = 3'b001;
    tick(); tick();
    running = 3'b001; irq_in = '0;
    tick();
    check("evtrun_serv", irq_in_service, 3'b001);
    check("evtrun_lost", lost_cnt, 8'd0);
    done = 3'b001;
    tick();
    done = '0;
    check("evtrun_repend", interrupt_req, 3'b001);
    tick();
    check("evtrun_serv2", irq_in_service, 3'b001);
    irq_in = 3'b001;
    tick(); tick();
    done = 3'b001; irq_in = '0;
    tick();
    done = '0;
    check("evtdone_pend", irq_pending, 3'b001);
    check("evtdone_lost", lost_cnt, 8'd0);
    tick();
    pulse(3'b001);
    check("preRst_serv", irq_in_service, 3'b001);
    check("preRst_svc", serviced_cnt, svc(16'd0, 16'd0, 16'd2));

    // Reset mid-service with again set
    clr_n = 1'b0;
    #1;
    check("rst2_serv", irq_in_service, 3'b000);
    check("rst2_req", interrupt_req, 3'b000);
    check("rst2_svc", serviced_cnt, 48'd0);
    running = '0;
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rst2_noreplay", irq_pending | interrupt_req | irq_in_service, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
